sram_scan_driver: RTL and testbench

//  Upstream master for the serial SRAM scan wrapper; runs on the wrapper's scan clock.

---
 rtl/sram_scan_driver_if.sv | 32 +++
 rtl/sram_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_sram_scan_driver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_scan_driver_if.sv
// Host-side bus of the serial SRAM scan driver: command, write-data and
// read-data handshakes plus transfer status. The host uses the master
// modport and the driver uses the slave modport.
interface sram_scan_driver_if #(
  parameter int N_ADDR = 32,
  parameter int N_CNT  = 33,
  parameter int N_DATA = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [N_ADDR-1:0] cmd_addr;
  logic [N_CNT-2:0]  cmd_count;
  logic [N_DATA-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [N_DATA-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              underrun;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_count, wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, underrun
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_count, wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, underrun
  );
endinterface

// File: rtl/sram_scan_driver.sv
// Upstream master for the serial SRAM scan wrapper. Takes one command,
// holds the wrapper in reset, shifts out the {addr, count, write} header
// LSB-first, then streams write words out or collects read words in.
// Optional feature macro: SCAN_DRV_LOOPBACK_EN adds the lpbk input, which
// makes the rx shifter sample scan_in_o delayed by one cycle instead of
// scan_out_i so the stream can be self-tested without an SRAM.
module sram_scan_driver #(
  parameter int N_ADDR       = 32,
  parameter int N_CNT        = 33,
  parameter int N_DATA       = 32,
  parameter int RST_CYCLES   = 4,
  parameter int RD_LAT_WORDS = 1
) (
  input  logic                    scan_clk,
  input  logic                    scan_rst,
  sram_scan_driver_if.slave       bus,
`ifdef SCAN_DRV_LOOPBACK_EN
  input  logic                    lpbk,
`endif
  output logic                    scan_rst_n_o,
  output logic                    scan_in_o,
  input  logic                    scan_out_i
);

  localparam int HDR_W = N_ADDR + N_CNT;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    DATA,
    DONE
  } state_t;

  state_t            state;
  logic [6:0]        bit_cnt;
  logic [N_CNT-1:0]  slot_cnt;
  logic [N_CNT-1:0]  count_q;
  logic              write_q;
  logic [HDR_W-1:0]  tx_sr;
  logic [N_DATA-1:0] rx_sr;
  logic              rx_bit;
  logic              last_bit;

`ifdef SCAN_DRV_LOOPBACK_EN
  logic scan_in_d;

  // One-cycle copy of the outgoing serial bit, used as the loopback source
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) scan_in_d <= 1'b0;
    else          scan_in_d <= scan_in_o;
  end

  assign rx_bit = lpbk ? scan_in_d : scan_out_i;
`else
  assign rx_bit = scan_out_i;
`endif

  // High in the final cycle of the header or of a data slot
  always_comb begin
    last_bit = 1'b0;
    if (state == HDR)  last_bit = (bit_cnt == 7'(HDR_W - 1));
    if (state == DATA) last_bit = (bit_cnt == 7'(N_DATA - 1));
  end

  // Transfer sequencer: reset phase, header shift, data slots, completion
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      slot_cnt     <= '0;
      count_q      <= '0;
      write_q      <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      scan_rst_n_o <= 1'b0;
      scan_in_o    <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.wr_ready  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.underrun  <= 1'b0;
    end else begin
      bus.wr_ready <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        IDLE: begin
          scan_rst_n_o <= 1'b0;
          scan_in_o    <= 1'b0;
          if (bus.cmd_valid && bus.cmd_ready) begin
            write_q  <= bus.cmd_write;
            count_q  <= N_CNT'(bus.cmd_count);
            slot_cnt <= bus.cmd_write ? N_CNT'(bus.cmd_count)
                                      : N_CNT'(bus.cmd_count) + N_CNT'(RD_LAT_WORDS);
            tx_sr    <= {bus.cmd_addr, bus.cmd_count, bus.cmd_write};
            bit_cnt  <= '0;
            bus.underrun  <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= PRE;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        PRE: begin
          if (bit_cnt == 7'(RST_CYCLES - 1)) begin
            scan_rst_n_o <= 1'b1;
            scan_in_o    <= tx_sr[0];
            tx_sr        <= tx_sr >> 1;
            bit_cnt      <= '0;
            state        <= HDR;
          end else begin
            bit_cnt <= bit_cnt + 7'd1;
          end
        end
        HDR, DATA: begin
          if (state == DATA) begin
            rx_sr <= {rx_bit, rx_sr[N_DATA-1:1]};
            if (last_bit && !write_q && (slot_cnt < count_q)) begin
              bus.rd_data  <= {rx_bit, rx_sr[N_DATA-1:1]};
              bus.rd_valid <= 1'b1;
            end
          end
          if (last_bit) begin
            bit_cnt <= '0;
            if (slot_cnt == '0) begin
              scan_rst_n_o <= 1'b0;
              scan_in_o    <= 1'b0;
              bus.done     <= 1'b1;
              state        <= DONE;
            end else begin
              slot_cnt <= slot_cnt - 1'b1;
              state    <= DATA;
              if (write_q && bus.wr_valid) begin
                tx_sr        <= HDR_W'(bus.wr_data >> 1);
                scan_in_o    <= bus.wr_data[0];
                bus.wr_ready <= 1'b1;
              end else begin
                tx_sr     <= '0;
                scan_in_o <= 1'b0;
                if (write_q) bus.underrun <= 1'b1;
              end
            end
          end else begin
            scan_in_o <= tx_sr[0];
            tx_sr     <= tx_sr >> 1;
            bit_cnt   <= bit_cnt + 7'd1;
          end
        end
        DONE: begin
          scan_rst_n_o  <= 1'b0;
          scan_in_o     <= 1'b0;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_scan_driver.sv
// Self-checking bench for sram_scan_driver: a bit-level reference of the
// expected scan stream, a wrapper model returning read words, directed
// scenarios and randomized transfers.
module tb_sram_scan_driver;
  localparam int N_DATA     = 32;
  localparam int HDR_W      = 65;
  localparam int RD_LAT     = 1;
  localparam int RST_CYCLES = 4;

  logic scan_clk = 1'b0;
  logic scan_rst;
  logic scan_rst_n_o;
  logic scan_in_o;
  logic scan_out_i;
`ifdef SCAN_DRV_LOOPBACK_EN
  logic lpbk;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_words[$];
  logic [31:0] rd_words[$];

  sram_scan_driver_if bus ();

  sram_scan_driver dut (
    .scan_clk     (scan_clk),
    .scan_rst     (scan_rst),
    .bus          (bus),
`ifdef SCAN_DRV_LOOPBACK_EN
    .lpbk         (lpbk),
`endif
    .scan_rst_n_o (scan_rst_n_o),
    .scan_in_o    (scan_in_o),
    .scan_out_i   (scan_out_i)
  );

  // Free-running scan clock
  always #5 scan_clk = ~scan_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer; wr_words / rd_words hold the data for it.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input int cnt,
                               input bit stall_last, input bit hold_cmd);
    bit          exp_q[$];
    bit          obs_q[$];
    logic [31:0] got_rd[$];
    logic [32:0] cnt_field;
    logic [31:0] w;
    int n_words, wr_idx, pre_len, n_wr_ready, mism, t, s, j, budget;
    bit accepted, seen_high, got_done;

    n_words    = (wr && stall_last && cnt > 0) ? cnt - 1 : cnt;
    cnt_field  = {cnt[31:0], wr};
    for (int i = 0; i < 33; i++) exp_q.push_back(cnt_field[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(addr[i]);
    if (wr) begin
      for (int k = 0; k < cnt; k++) begin
        w = (k < n_words) ? wr_words[k] : 32'h0;
        for (int i = 0; i < N_DATA; i++) exp_q.push_back(w[i]);
      end
    end else begin
      for (int k = 0; k < (cnt + RD_LAT) * N_DATA; k++) exp_q.push_back(1'b0);
    end

    wr_idx = 0; pre_len = 0; n_wr_ready = 0;
    accepted = 0; seen_high = 0; got_done = 0;
    budget = 300 + N_DATA * (cnt + RD_LAT);

    @(negedge scan_clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_count = cnt[31:0];
    bus.wr_valid  = (n_words > 0);
    bus.wr_data   = (n_words > 0) ? wr_words[0] : 32'h0;

    for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
      @(negedge scan_clk);
      if (!accepted && bus.busy) begin
        accepted = 1;
        checkOutput("underrun_cleared_on_accept", 64'(bus.underrun), 64'(0));
        if (hold_cmd) bus.cmd_addr = ~addr;
        else          bus.cmd_valid = 1'b0;
      end
      if (accepted) begin
        if (hold_cmd && cyc == 30)
          checkOutput("cmd_ready_while_busy", 64'(bus.cmd_ready), 64'(0));
        if (!scan_rst_n_o && !seen_high && !bus.done) pre_len++;
        if (scan_rst_n_o) begin
          seen_high = 1;
          t = obs_q.size();
          obs_q.push_back(scan_in_o);
          scan_out_i = 1'($urandom);
          if (!wr && t >= HDR_W) begin
            s = (t - HDR_W) / N_DATA;
            j = (t - HDR_W) % N_DATA;
            if (s >= RD_LAT && (s - RD_LAT) < rd_words.size()) begin
              w = rd_words[s - RD_LAT];
              scan_out_i = w[j];
            end
          end
        end
        if (bus.wr_ready) begin
          n_wr_ready++;
          wr_idx++;
          bus.wr_valid = (wr_idx < n_words);
          if (wr_idx < n_words) bus.wr_data = wr_words[wr_idx];
        end
        if (bus.rd_valid) got_rd.push_back(bus.rd_data);
        if (bus.done) begin
          got_done = 1;
          checkOutput("done_one_cycle_after_last_bit", 64'(obs_q.size()), 64'(exp_q.size()));
          checkOutput("rst_n_low_in_done", 64'(scan_rst_n_o), 64'(0));
        end
      end
    end

    checkOutput("done_seen", 64'(got_done), 64'(1));
    checkOutput("pre_reset_cycles", 64'(pre_len), 64'(RST_CYCLES));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) mism++;
    checkOutput("scan_stream_bit_errors", 64'(mism), 64'(0));
    checkOutput("wr_ready_pulses", 64'(n_wr_ready), 64'(wr ? n_words : 0));
    checkOutput("rd_valid_pulses", 64'(got_rd.size()), 64'(wr ? 0 : cnt));
    for (int i = 0; i < got_rd.size() && i < rd_words.size(); i++)
      checkOutput("rd_word", 64'(got_rd[i]), 64'(rd_words[i]));
    checkOutput("underrun_flag", 64'(bus.underrun), 64'(wr && stall_last && cnt > 0));

    @(negedge scan_clk);
    checkOutput("idle_after_done", 64'({bus.busy, bus.cmd_ready}), 64'(2'b01));
    if (hold_cmd) begin
      @(negedge scan_clk);
      checkOutput("held_cmd_accepted_after_done", 64'(bus.busy), 64'(1));
    end
  endtask

  task automatic fillWords(input int cnt, input bit rd);
    wr_words.delete();
    rd_words.delete();
    for (int i = 0; i < cnt; i++) begin
      if (rd) rd_words.push_back($urandom);
      else    wr_words.push_back($urandom);
    end
  endtask

  initial begin
    logic wr;
    int   cnt;
    bit   stall;

    scan_rst      = 1'b1;
    scan_out_i    = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_count = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
`ifdef SCAN_DRV_LOOPBACK_EN
    lpbk = 1'b0;
`endif
    repeat (3) @(negedge scan_clk);
    checkOutput("reset_outputs", 64'({bus.busy, bus.cmd_ready, bus.done, bus.wr_ready,
                bus.rd_valid, bus.underrun, scan_rst_n_o, scan_in_o}), 64'(0));
    scan_rst = 1'b0;
    @(negedge scan_clk);
    checkOutput("ready_after_reset", 64'(bus.cmd_ready), 64'(1));

    $display("[TB] directed write of two words at 0x10");
    wr_words = '{32'hDEADBEEF, 32'h12345678};
    applyStimulus(1'b1, 32'h10, 2, 1'b0, 1'b0);

    $display("[TB] directed read of three words");
    rd_words = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000};
    applyStimulus(1'b0, 32'h200, 3, 1'b0, 1'b0);

    $display("[TB] reset in the middle of the header");
    @(negedge scan_clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'hFFFFFFFF;
    bus.cmd_count = 32'd1; bus.wr_valid = 1'b1; bus.wr_data = 32'hFFFFFFFF;
    @(negedge scan_clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 50 && !scan_rst_n_o; i++) @(negedge scan_clk);
    checkOutput("header_reached", 64'(scan_rst_n_o), 64'(1));
    repeat (40) @(negedge scan_clk);
    #2 scan_rst = 1'b1;
    #1;
    checkOutput("abort_outputs", 64'({bus.busy, bus.cmd_ready, bus.done, bus.wr_ready,
                bus.rd_valid, bus.underrun, scan_rst_n_o, scan_in_o}), 64'(0));
    checkOutput("abort_rd_data", 64'(bus.rd_data), 64'(0));
    @(negedge scan_clk);
    scan_rst = 1'b0;
    @(negedge scan_clk);
    checkOutput("ready_after_abort", 64'({bus.busy, bus.cmd_ready}), 64'(2'b01));

    $display("[TB] write underrun on the last slot");
    wr_words = '{32'hCAFEF00D};
    applyStimulus(1'b1, 32'h44, 2, 1'b1, 1'b0);
    checkOutput("underrun_sticky", 64'(bus.underrun), 64'(1));

    $display("[TB] command held while busy");
    wr_words = '{32'h13579BDF};
    applyStimulus(1'b1, 32'h40, 1, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
    scan_rst = 1'b1;
    @(negedge scan_clk);
    scan_rst = 1'b0;
    @(negedge scan_clk);

    $display("[TB] zero-count transfers");
    fillWords(0, 1'b0);
    applyStimulus(1'b1, 32'h80000001, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h7FFFFFFE, 0, 1'b0, 1'b0);

`ifdef SCAN_DRV_LOOPBACK_EN
    $display("[TB] loopback read");
    lpbk = 1'b1;
    rd_words = '{32'h0};
    applyStimulus(1'b0, 32'h0, 1, 1'b0, 1'b0);
    lpbk = 1'b0;
`endif

    $display("[TB] randomized transfers");
    for (int k = 0; k < 10; k++) begin
      wr    = 1'($urandom);
      cnt   = $urandom_range(0, 3);
      stall = wr && ($urandom_range(0, 2) == 0);
      fillWords(cnt, !wr);
      applyStimulus(wr, $urandom, cnt, stall, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
